// File: rtl/stack_seq_ctrl_if.sv
// Command/response handshake bundle for stack_seq_ctrl.
// master drives commands and consumes responses; slave is the controller.
interface stack_seq_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_seq_ctrl.sv
// Sequencer that executes stack-machine commands against an external stack
// through single-cycle tos/pop/push strobes, one command at a time.
module stack_seq_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  stack_seq_ctrl_if.slave   bus,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_tos,
  output logic [W-1:0]      stk_din,
  input  logic [W-1:0]      stk_dout,
  output logic [3:0]        depth
);

  typedef enum logic [2:0] {
    OpPush, OpPop, OpAdd, OpSub, OpAnd, OpOr, OpNot, OpDup
  } op_e;

  typedef enum logic [2:0] {
    StIdle, StTosA, StPopA, StTosB, StPopB, StExec, StPushR, StResp
  } state_e;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic         err_q, err_d;
  logic [3:0]   depth_q, depth_d;
  logic         rdy_q;
  logic         under, over;

  // rdy_q holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpPush;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      depth_q <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    under = 1'b0;
    over  = 1'b0;
    unique case (op_e'(bus.cmd_op))
      OpPush:       over  = (depth_q == 4'(DEPTH));
      OpPop, OpNot: under = (depth_q == 4'd0);
      OpDup: begin
        under = (depth_q == 4'd0);
        over  = (depth_q == 4'(DEPTH));
      end
      default:      under = (depth_q < 4'd2);
    endcase

    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    err_d   = err_q;
    depth_d = depth_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && rdy_q) begin
          op_d  = op_e'(bus.cmd_op);
          r_d   = bus.cmd_data;
          err_d = under || over;
          if (under || over)                    state_d = StResp;
          else if (op_e'(bus.cmd_op) == OpPush) state_d = StPushR;
          else                                  state_d = StTosA;
        end
      end
      StTosA: state_d = StPopA;
      StPopA: begin
        // r also takes A so POP and DUP respond/push it without an EXEC step.
        a_d = stk_dout;
        r_d = stk_dout;
        if (op_q != OpDup) depth_d = depth_q - 4'd1;
        unique case (op_q)
          OpPop:   state_d = StResp;
          OpDup:   state_d = StPushR;
          OpNot:   state_d = StExec;
          default: state_d = StTosB;
        endcase
      end
      StTosB: state_d = StPopB;
      StPopB: begin
        b_d     = stk_dout;
        depth_d = depth_q - 4'd1;
        state_d = StExec;
      end
      StExec: begin
        unique case (op_q)
          OpAdd:   r_d = b_q + a_q;
          OpSub:   r_d = b_q - a_q;
          OpAnd:   r_d = b_q & a_q;
          OpOr:    r_d = b_q | a_q;
          OpNot:   r_d = ~a_q;
          default: r_d = r_q;
        endcase
        state_d = StPushR;
      end
      StPushR: begin
        depth_d = depth_q + 4'd1;
        state_d = StResp;
      end
      StResp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == StIdle) && rdy_q;
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_err   = (state_q == StResp) && err_q;
    bus.rsp_data  = ((state_q == StResp) && !err_q) ? r_q : '0;
    stk_tos       = (state_q == StTosA) || (state_q == StTosB);
    stk_pop       = (state_q == StPopB) || ((state_q == StPopA) && (op_q != OpDup));
    stk_push      = (state_q == StPushR);
    stk_din       = (state_q == StPushR) ? r_q : '0;
    depth         = depth_q;
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl with a behavioural stack model and a
// strobe trace (1=tos, 2=pop, 3=push) for checking strobe ordering.
module tb_stack_seq_ctrl;
  logic       clk;
  logic       rst_n;
  logic       stk_push, stk_pop, stk_tos;
  logic [7:0] stk_din, stk_dout;
  logic [3:0] depth;

  int n_assert = 0;
  int n_fail   = 0;
  int n_multi  = 0;
  int trace[$];

  logic [7:0] mem [16];
  int         sp;

  stack_seq_ctrl_if #(.W(8)) bus ();

  stack_seq_ctrl #(.W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_tos  (stk_tos),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .depth    (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= 0;
      stk_dout <= 8'h00;
    end else begin
      if ((stk_tos || stk_pop) && sp > 0) stk_dout <= mem[sp-1];
      if (stk_pop && sp > 0) sp <= sp - 1;
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_din;
        sp      <= sp + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (stk_tos)  trace.push_back(1);
      if (stk_pop)  trace.push_back(2);
      if (stk_push) trace.push_back(3);
      if (int'(stk_tos) + int'(stk_pop) + int'(stk_push) > 1) n_multi++;
    end
  end

  function automatic int trace_code(input int from);
    int c = 0;
    for (int i = from; i < trace.size(); i++) c = c * 16 + trace[i];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input int stall,
                         output logic [7:0] d, output logic e, output int lat);
    int w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = op + 3'd1;
    bus.cmd_data  = ~data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    if (!bus.rsp_valid) chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_data", 32'(bus.rsp_data), 32'(d));
      chk("stall_err", 32'(bus.rsp_err), 32'(e));
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmd_chk(input string tag, input logic [2:0] op, input logic [7:0] data,
                         input int stall, input logic [7:0] exp_d, input logic exp_e,
                         input int exp_lat, input logic [3:0] exp_depth);
    logic [7:0] d;
    logic       e;
    int         lat;
    run_cmd(op, data, stall, d, e, lat);
    chk({tag, "_data"}, 32'(d), 32'(exp_d));
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_depth"}, 32'(depth), 32'(exp_depth));
  endtask

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, OR_ = 3'd5, NOT_ = 3'd6, DUP = 3'd7;

  initial begin
    int t0;
    int seen;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_strobes", 32'({stk_tos, stk_pop, stk_push}), 32'd0);
    chk("rst_stk_din", 32'(stk_din), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    cmd_chk("push80", PUSH, 8'h80, 0, 8'h80, 1'b0, 2, 4'd1);
    cmd_chk("push55", PUSH, 8'h55, 0, 8'h55, 1'b0, 2, 4'd2);
    t0 = trace.size();
    cmd_chk("sub", SUB, 8'h00, 0, 8'h2B, 1'b0, 7, 4'd1);
    chk("sub_strobe_order", 32'(trace_code(t0)), 32'h12123);
    cmd_chk("pop", POP, 8'h00, 0, 8'h2B, 1'b0, 3, 4'd0);
    t0 = trace.size();
    cmd_chk("pop_empty", POP, 8'h00, 0, 8'h00, 1'b1, 1, 4'd0);
    chk("pop_empty_strobes", 32'(trace.size() - t0), 32'd0);

    cmd_chk("pushff", PUSH, 8'hFF, 0, 8'hFF, 1'b0, 2, 4'd1);
    cmd_chk("push02", PUSH, 8'h02, 0, 8'h02, 1'b0, 2, 4'd2);
    cmd_chk("add_wrap", ADD, 8'h00, 0, 8'h01, 1'b0, 7, 4'd1);
    t0 = trace.size();
    cmd_chk("not", NOT_, 8'h00, 0, 8'hFE, 1'b0, 5, 4'd1);
    chk("not_strobe_order", 32'(trace_code(t0)), 32'h123);
    t0 = trace.size();
    cmd_chk("dup", DUP, 8'h00, 0, 8'hFE, 1'b0, 4, 4'd2);
    chk("dup_strobe_order", 32'(trace_code(t0)), 32'h13);
    cmd_chk("and", AND_, 8'h00, 0, 8'hFE, 1'b0, 7, 4'd1);
    cmd_chk("push0f", PUSH, 8'h0F, 0, 8'h0F, 1'b0, 2, 4'd2);
    cmd_chk("or", OR_, 8'h00, 0, 8'hFF, 1'b0, 7, 4'd1);
    for (int i = 1; i <= 7; i++)
      cmd_chk("fill", PUSH, 8'(i), 0, 8'(i), 1'b0, 2, 4'(i + 1));
    t0 = trace.size();
    cmd_chk("dup_full", DUP, 8'h00, 0, 8'h00, 1'b1, 1, 4'd8);
    cmd_chk("push_full", PUSH, 8'hAA, 0, 8'h00, 1'b1, 1, 4'd8);
    chk("full_err_strobes", 32'(trace.size() - t0), 32'd0);

    bus.rsp_ready = 1'b0;
    cmd_chk("pop_stall", POP, 8'h00, 5, 8'h07, 1'b0, 3, 4'd7);
    cmd_chk("sub_wrap", SUB, 8'h00, 0, 8'hFF, 1'b0, 7, 4'd6);

    // Abort an ADD while it sits in TOS_B.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = ADD;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_tos_a", 32'(stk_tos), 32'd1);
    @(negedge clk);
    chk("abort_pop_a", 32'(stk_pop), 32'd1);
    @(negedge clk);
    chk("abort_tos_b", 32'(stk_tos), 32'd1);
    chk("abort_depth_pre", 32'(depth), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("abort_depth", 32'(depth), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_strobes", 32'({stk_tos, stk_pop, stk_push}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("abort_no_response", 32'(seen), 32'd0);
    cmd_chk("post_push", PUSH, 8'h33, 0, 8'h33, 1'b0, 2, 4'd1);
    cmd_chk("post_pop", POP, 8'h00, 0, 8'h33, 1'b0, 3, 4'd0);
    chk("single_strobe", 32'(n_multi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
